load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage for the RV32I core. Takes the effective address computed by the ALU (rs1 + imm), plus the instruction and rs2, and performs one LOAD or STORE data access.
- Uses a valid/ready data-memory port.
- Produces a sign- or zero-extended load result for writeback, plus a one-cycle completion pulse that the control FSM waits on.

Parameters:
- WAIT_LIMIT, 255: maximum number of cycles to hold mem_valid without mem_ready before raising fault. A value of 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request. instruction, addr and store_data are valid in the same cycle.
- instruction  in  32  current instruction; opcode [6:0] and funct3 [14:12] are decoded.
- addr  in  32  effective byte address (ALU out).
- store_data  in  32  rs2 value.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result.
- misaligned  out  1  qualifies done: address is not aligned to the access size.
- fault  out  1  qualifies done: illegal funct3 or memory timeout.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts the request; for loads, read data is valid in the same cycle.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address {addr[31:2], 2'b00}.
- mem_wstrb  out  4  byte-lane enables; 0 for loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data.

Behaviour:
- Reset values: busy = 0, done = 0, misaligned = 0, fault = 0, mem_valid = 0, mem_we = 0, mem_wstrb = 0, mem_addr = 0, mem_wdata = 0, load_data = 0. State = IDLE, timeout counter = 0.
- States: IDLE, REQ, RESP.
- IDLE, start high with opcode LOAD or STORE:
  - Latch the request and go to REQ.
  - If the access is misaligned or funct3 is illegal, go to RESP with the flag set and never assert mem_valid.
- IDLE, start high with any other opcode: ignored, no done.
- start while busy: ignored.
- Legal funct3:
  - LOAD: LB, LH, LW, LBU, LHU.
  - STORE: SB, SH, SW.
  - Anything else sets fault.
- Alignment:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Byte is always aligned.
- REQ:
  - mem_valid = 1; addr, we, wstrb and wdata stay stable until mem_ready is sampled high.
  - On that edge: capture the extended load data (loads only), deassert mem_valid, go to RESP.
- Timeout: counter increments each REQ cycle with mem_ready low. When WAIT_LIMIT ≠ 0 and WAIT_LIMIT consecutive unready cycles have elapsed, go to RESP with fault = 1 and mem_valid dropped.
- RESP: done = 1 for exactly one cycle; misaligned and fault are valid in that same cycle; then return to IDLE. misaligned and fault are 0 whenever done = 0.
- Latency:
  - start at cycle 0 → mem_valid in cycle 1.
  - mem_ready in cycle 1 → done in cycle 2.
  - Misaligned or illegal request → done in cycle 1.
- Store lanes:
  - SB: wstrb = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011 << {addr[1], 1'b0}, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = rs2.
- Load extraction:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- load_data updates only on a successful load and holds its value across stores and faults.
- Reset mid-REQ: at the reset edge all outputs return to their reset values; no done is produced for the aborted access.

Decomposition:
- params.vh gains OPCODE_LOAD, OPCODE_STORE and FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW.
- The state enum typedef lsu_state_t goes in the shared package.
- Sub-module lsu_align (combinational): from funct3, addr[1:0], rs2 and rdata, produces wstrb, wdata, extended load data and the misaligned flag. The FSM, timeout counter and request registers live in the top module.

Test Plan:
- LW at addr 0x0000_0100, mem_ready high in the first REQ cycle, rdata 0xDEAD_BEEF → mem_addr 0x100, wstrb 0, done in cycle 2, load_data 0xDEAD_BEEF.
- LB at addr 0x103, rdata 0x80AA_BBCC → load_data 0xFFFF_FF80. LBU with the same inputs → 0x0000_0080. LHU at 0x102, rdata 0xBEEF_1234 → 0x0000_BEEF.
- SB at 0x101 with rs2 0x1234_56A5, mem_ready delayed 3 cycles → mem_valid held 4 cycles with mem_we = 1, wstrb 0010 and wdata 0xA5A5_A5A5 stable throughout; done one cycle after ready.
- LW at 0x102 → done in cycle 1 with misaligned = 1 and mem_valid never high. LOAD with funct3 011 → done with fault = 1.
- WAIT_LIMIT = 4, mem_ready stuck low → mem_valid high for exactly 4 cycles, then done with fault = 1; load_data unchanged.
- reset asserted in the 2nd REQ cycle → mem_valid = 0 and busy = 0 next cycle, no done. A following start works normally. A start issued while busy is ignored.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and RV32I encodings for the load/store unit.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP
  } lsu_state_t;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // True when funct3 names a real access for the given direction.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) begin
      return (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
    end
    return (funct3 == FUNCT3_LB)  || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
           (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Valid/ready data-memory port between the load/store unit and memory.
interface load_store_unit_if;

  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store strobes/data, load extraction and extension,
// alignment and funct3 legality checks. Purely combinational.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Lane selection and sign/zero extension for every access size.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    wstrb      = 4'b0000;
    wdata      = 32'h0;
    load_ext   = 32'h0;
    misaligned = 1'b0;
    illegal    = !funct3_legal(is_store, funct3);

    case (addr_lo)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3[1:0])
      2'b00: begin
        wstrb    = 4'b0001 << addr_lo;
        wdata    = {4{rs2[7:0]}};
        load_ext = funct3[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      2'b01: begin
        misaligned = addr_lo[0];
        wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{rs2[15:0]}};
        load_ext   = funct3[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      2'b10: begin
        misaligned = (addr_lo != 2'b00);
        wstrb      = 4'b1111;
        wdata      = rs2;
        load_ext   = rdata;
      end
      default: ;
    endcase

    // An illegal funct3 has no defined size, so it reports only as a fault.
    if (illegal) misaligned = 1'b0;
    if (!is_store) wstrb = 4'b0000;
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one LOAD or STORE per start pulse over a valid/ready
// port, with alignment/legality checks and a bounded wait for mem_ready.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        instruction,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  output logic               busy,
  output logic               done,
  output logic [31:0]        load_data,
  output logic               misaligned,
  output logic               fault,
  load_store_unit_if.master  mem
);

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  lsu_state_t state, state_n;

  logic [2:0]    funct3_q;
  logic [1:0]    addr_lo_q;
  logic          is_store_q;
  logic          we_q;
  logic [31:0]   mem_addr_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   wdata_q;
  logic [31:0]   load_data_q;
  logic          mis_q;
  logic          fault_q;
  logic [CW-1:0] wait_cnt;

  logic [6:0]  opcode;
  logic        req_load;
  logic        req_store;
  logic        accept;
  logic        reject;
  logic        timeout;

  logic [2:0]  a_funct3;
  logic        a_is_store;
  logic [1:0]  a_addr_lo;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata;
  logic [31:0] a_load;
  logic        a_mis;
  logic        a_illegal;

  assign opcode    = instruction[6:0];
  assign req_load  = (opcode == OPCODE_LOAD);
  assign req_store = (opcode == OPCODE_STORE);
  assign accept    = start && (state == LSU_IDLE) && (req_load || req_store);
  assign reject    = a_mis || a_illegal;
  assign timeout   = (WAIT_LIMIT != 0) && !mem.mem_ready && (wait_cnt == WAIT_LAST);

  // Aligner sees the incoming request while idle and the latched one afterwards.
  always_comb begin
    a_funct3   = funct3_q;
    a_is_store = is_store_q;
    a_addr_lo  = addr_lo_q;
    if (state == LSU_IDLE) begin
      a_funct3   = instruction[14:12];
      a_is_store = req_store;
      a_addr_lo  = addr[1:0];
    end
  end

  lsu_align u_align (
    .funct3     (a_funct3),
    .is_store   (a_is_store),
    .addr_lo    (a_addr_lo),
    .rs2        (store_data),
    .rdata      (mem.mem_rdata),
    .wstrb      (a_wstrb),
    .wdata      (a_wdata),
    .load_ext   (a_load),
    .misaligned (a_mis),
    .illegal    (a_illegal)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= LSU_IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      LSU_IDLE: if (accept) state_n = reject ? LSU_RESP : LSU_REQ;
      LSU_REQ:  if (mem.mem_ready || timeout) state_n = LSU_RESP;
      LSU_RESP: state_n = LSU_IDLE;
      default:  state_n = LSU_IDLE;
    endcase
  end

  // Request latch, wait counter, result flags and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      is_store_q  <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= 32'h0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= 32'h0;
      load_data_q <= 32'h0;
      mis_q       <= 1'b0;
      fault_q     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            funct3_q   <= instruction[14:12];
            addr_lo_q  <= addr[1:0];
            is_store_q <= req_store;
            we_q       <= req_store;
            mem_addr_q <= {addr[31:2], 2'b00};
            wstrb_q    <= a_wstrb;
            wdata_q    <= a_wdata;
            mis_q      <= a_mis;
            fault_q    <= a_illegal;
            wait_cnt   <= '0;
          end
        end
        LSU_REQ: begin
          if (mem.mem_ready) begin
            if (!is_store_q) load_data_q <= a_load;
          end else if (timeout) begin
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != LSU_IDLE);
  assign done       = (state == LSU_RESP);
  assign misaligned = done && mis_q;
  assign fault      = done && fault_q;
  assign load_data  = load_data_q;

  assign mem.mem_valid = (state == LSU_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wstrb = wstrb_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit_if mem_if ();

  load_store_unit #(.WAIT_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .load_data   (load_data),
    .misaligned  (misaligned),
    .fault       (fault),
    .mem         (mem_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'h0, f3, 5'h0, op};
  endfunction

  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] sd);
    start       = 1'b1;
    instruction = instr;
    addr        = a;
    store_data  = sd;
    tick();
    start = 1'b0;
  endtask

  // Load answered in the first REQ cycle: done two cycles after start.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    issue(mk(f3, OP_LOAD), a, 32'h0);
    check({tag, "_valid"}, 32'(mem_if.mem_valid), 32'h1);
    check({tag, "_addr"},  mem_if.mem_addr, {a[31:2], 2'b00});
    check({tag, "_strb"},  32'(mem_if.mem_wstrb), 32'h0);
    check({tag, "_done0"}, 32'(done), 32'h0);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = rd;
    tick();
    mem_if.mem_ready = 1'b0;
    check({tag, "_done"},  32'(done), 32'h1);
    check({tag, "_flags"}, {30'h0, misaligned, fault}, 32'h0);
    check({tag, "_data"},  load_data, exp);
    check({tag, "_vdrop"}, 32'(mem_if.mem_valid), 32'h0);
    tick();
    check({tag, "_idle"},  {30'h0, busy, done}, 32'h0);
  endtask

  // Store with mem_ready held off for 'delay' REQ cycles.
  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int delay,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    issue(mk(f3, OP_STORE), a, sd);
    for (int i = 0; i <= delay; i++) begin
      check({tag, "_valid"}, 32'(mem_if.mem_valid), 32'h1);
      check({tag, "_we"},    32'(mem_if.mem_we), 32'h1);
      check({tag, "_strb"},  32'(mem_if.mem_wstrb), 32'(exp_strb));
      check({tag, "_wdata"}, mem_if.mem_wdata, exp_wdata);
      check({tag, "_done0"}, 32'(done), 32'h0);
      if (i == delay) mem_if.mem_ready = 1'b1;
      tick();
    end
    mem_if.mem_ready = 1'b0;
    check({tag, "_done"},  32'(done), 32'h1);
    check({tag, "_flags"}, {30'h0, misaligned, fault}, 32'h0);
    check({tag, "_vdrop"}, 32'(mem_if.mem_valid), 32'h0);
    tick();
    check({tag, "_idle"},  {30'h0, busy, done}, 32'h0);
  endtask

  // Rejected request: done in cycle 1, no memory traffic.
  task automatic run_bad(input string tag, input logic [31:0] instr, input logic [31:0] a,
                         input logic exp_mis, input logic exp_fault);
    issue(instr, a, 32'h0);
    check({tag, "_done"},  32'(done), 32'h1);
    check({tag, "_mis"},   32'(misaligned), 32'(exp_mis));
    check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
    check({tag, "_valid"}, 32'(mem_if.mem_valid), 32'h0);
    tick();
    check({tag, "_idle"},  {30'h0, busy, done}, 32'h0);
    check({tag, "_flag0"}, {30'h0, misaligned, fault}, 32'h0);
  endtask

  initial begin
    int valid_cycles;
    reset            = 1'b1;
    start            = 1'b0;
    instruction      = 32'h0;
    addr             = 32'h0;
    store_data       = 32'h0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = 32'h0;
    tick();
    tick();
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_flags", {30'h0, misaligned, fault}, 32'h0);
    check("rst_valid", 32'(mem_if.mem_valid), 32'h0);
    check("rst_we",    32'(mem_if.mem_we), 32'h0);
    check("rst_strb",  32'(mem_if.mem_wstrb), 32'h0);
    check("rst_addr",  mem_if.mem_addr, 32'h0);
    check("rst_wdata", mem_if.mem_wdata, 32'h0);
    check("rst_ldata", load_data, 32'h0);
    reset = 1'b0;
    tick();

    // Loads across lanes and extension modes.
    run_load("lw",     3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb",     3'b000, 32'h0000_0103, 32'h80AA_BBCC, 32'hFFFF_FF80);
    run_load("lbu",    3'b100, 32'h0000_0103, 32'h80AA_BBCC, 32'h0000_0080);
    run_load("lhu",    3'b101, 32'h0000_0102, 32'hBEEF_1234, 32'h0000_BEEF);
    run_load("lh_hi",  3'b001, 32'h0000_0102, 32'hBEEF_1234, 32'hFFFF_BEEF);
    run_load("lb_b1",  3'b000, 32'h0000_0201, 32'h0000_7F00, 32'h0000_007F);
    run_load("lh_lo",  3'b001, 32'h0000_0100, 32'h1234_8001, 32'hFFFF_8001);

    // Stores: lane strobes and replicated data.
    run_store("sb", 3'b000, 32'h0000_0101, 32'h1234_56A5, 3, 4'b0010, 32'hA5A5_A5A5);
    run_store("sh", 3'b001, 32'h0000_0102, 32'h0000_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
    run_store("sw", 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);
    check("st_hold_ldata", load_data, 32'hFFFF_8001);

    // Misaligned and illegal requests.
    run_bad("lw_mis",  mk(3'b010, OP_LOAD),  32'h0000_0102, 1'b1, 1'b0);
    run_bad("sh_mis",  mk(3'b001, OP_STORE), 32'h0000_0101, 1'b1, 1'b0);
    run_bad("ld_f011", mk(3'b011, OP_LOAD),  32'h0000_0100, 1'b0, 1'b1);
    run_bad("st_f100", mk(3'b100, OP_STORE), 32'h0000_0100, 1'b0, 1'b1);
    check("bad_hold_ldata", load_data, 32'hFFFF_8001);

    // Non-memory opcode is ignored.
    issue(mk(3'b000, OP_ALU), 32'h0000_0100, 32'h0);
    check("alu_ignored", {30'h0, busy, done}, 32'h0);
    tick();
    check("alu_nodone", 32'(done), 32'h0);

    // Timeout with WAIT_LIMIT = 4 and mem_ready stuck low.
    issue(mk(3'b010, OP_LOAD), 32'h0000_0200, 32'h0);
    mem_if.mem_rdata = 32'h1111_1111;
    valid_cycles = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mem_if.mem_valid) valid_cycles++;
      tick();
    end
    check("to_valid_cycles", 32'(valid_cycles), 32'd4);
    check("to_done",  32'(done), 32'h1);
    check("to_fault", 32'(fault), 32'h1);
    check("to_mis",   32'(misaligned), 32'h0);
    check("to_vdrop", 32'(mem_if.mem_valid), 32'h0);
    check("to_ldata", load_data, 32'hFFFF_8001);
    tick();
    check("to_idle", {30'h0, busy, done}, 32'h0);

    // Reset during the second REQ cycle aborts without done.
    issue(mk(3'b010, OP_LOAD), 32'h0000_0300, 32'h0);
    check("ra_req1", 32'(mem_if.mem_valid), 32'h1);
    tick();
    check("ra_req2", 32'(mem_if.mem_valid), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ra_valid", 32'(mem_if.mem_valid), 32'h0);
    check("ra_busy",  32'(busy), 32'h0);
    check("ra_done",  32'(done), 32'h0);
    check("ra_ldata", load_data, 32'h0);
    tick();
    check("ra_nodone", 32'(done), 32'h0);
    run_load("ra_after", 3'b010, 32'h0000_0040, 32'h1122_3344, 32'h1122_3344);

    // start held while busy with a different request is ignored.
    issue(mk(3'b010, OP_LOAD), 32'h0000_0300, 32'h0);
    start       = 1'b1;
    instruction = mk(3'b010, OP_STORE);
    addr        = 32'h0000_0400;
    store_data  = 32'h9999_9999;
    check("bz_addr1", mem_if.mem_addr, 32'h0000_0300);
    check("bz_we1",   32'(mem_if.mem_we), 32'h0);
    tick();
    check("bz_valid2", 32'(mem_if.mem_valid), 32'h1);
    check("bz_addr2",  mem_if.mem_addr, 32'h0000_0300);
    check("bz_we2",    32'(mem_if.mem_we), 32'h0);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'h5566_7788;
    tick();
    mem_if.mem_ready = 1'b0;
    start            = 1'b0;
    check("bz_done",  32'(done), 32'h1);
    check("bz_ldata", load_data, 32'h5566_7788);
    tick();
    check("bz_idle",  {30'h0, busy, done}, 32'h0);
    tick();
    check("bz_stay",  {30'h0, busy, done}, 32'h0);
    check("bz_valid", 32'(mem_if.mem_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
